// File: rtl/rs_pkg.sv
// Shared types and widths for the ALU reservation station.
// Widths follow the project-wide defines when present, otherwise the local defaults.
`ifndef TAG_WIDTH
`define TAG_WIDTH 6
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 5
`endif
`ifndef RS_ALU_ENTRIES_NUM
`define RS_ALU_ENTRIES_NUM 8
`endif
`ifndef NUM_OF_ALUS
`define NUM_OF_ALUS 2
`endif

package rs_pkg;

  localparam int TAG_WIDTH          = `TAG_WIDTH;
  localparam int DATA_WIDTH         = `DATA_WIDTH;
  localparam int OP_WIDTH           = `OP_WIDTH;
  localparam int RS_ALU_ENTRIES_NUM = `RS_ALU_ENTRIES_NUM;
  localparam int NUM_OF_ALUS        = `NUM_OF_ALUS;

  typedef struct packed {
    logic                  rdy;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic                 valid;
    logic [OP_WIDTH-1:0]  op;
    logic [TAG_WIDTH-1:0] dst_tag;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_entry_t;

endpackage

// File: rtl/rs_src_wakeup.sv
// Next-state logic for one source operand: picks the allocated or stored source,
// then captures a matching CDB broadcast (lowest lane wins).
module rs_src_wakeup
  import rs_pkg::*;
#(
  parameter int NUM_OF_FU = NUM_OF_ALUS
) (
  input  logic                                 active,
  input  rs_src_t                              cur,
  input  logic                                 alloc_en,
  input  rs_src_t                              alloc_src,
  input  logic [NUM_OF_FU-1:0]                 cdb_valid,
  input  logic [NUM_OF_FU-1:0][TAG_WIDTH-1:0]  cdb_tag,
  input  logic [NUM_OF_FU-1:0][DATA_WIDTH-1:0] cdb_val,
  output rs_src_t                              nxt,
  output logic                                 multi_hit
);

  rs_src_t              base;
  logic [NUM_OF_FU-1:0] hit;

  // Scanning from the top lane down lets the lowest matching lane overwrite last.
  always_comb begin
    base = alloc_en ? alloc_src : cur;
    nxt  = base;
    hit  = '0;
    for (int k = NUM_OF_FU - 1; k >= 0; k--) begin
      hit[k] = cdb_valid[k] && (cdb_tag[k] == base.tag) && !base.rdy;
      if (hit[k]) begin
        nxt.rdy = 1'b1;
        nxt.val = cdb_val[k];
      end
    end
    multi_hit = (alloc_en || active) && ($countones(hit) > 1);
  end

endmodule

// File: rtl/rs_alu_station.sv
// ALU reservation-station entry array: allocation, CDB wakeup, and a registered
// per-FU issue port driven by the scheduler's dispatch grants.
module rs_alu_station
  import rs_pkg::*;
#(
  parameter int NUM_OF_RS      = RS_ALU_ENTRIES_NUM,
  parameter int NUM_OF_FU      = NUM_OF_ALUS,
  parameter int FU_IDX_WIDTH   = (NUM_OF_FU <= 1) ? 1 : $clog2(NUM_OF_FU),
  parameter bit CHECK_PROTOCOL = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   alloc_valid,
  output logic                                   alloc_ready,
  input  logic [OP_WIDTH-1:0]                    alloc_op,
  input  logic [TAG_WIDTH-1:0]                   alloc_dst_tag,
  input  logic [TAG_WIDTH-1:0]                   alloc_src1_tag,
  input  logic                                   alloc_src1_rdy,
  input  logic [DATA_WIDTH-1:0]                  alloc_src1_val,
  input  logic [TAG_WIDTH-1:0]                   alloc_src2_tag,
  input  logic                                   alloc_src2_rdy,
  input  logic [DATA_WIDTH-1:0]                  alloc_src2_val,
  input  logic [NUM_OF_FU-1:0]                   cdb_valid,
  input  logic [NUM_OF_FU-1:0][TAG_WIDTH-1:0]    cdb_tag,
  input  logic [NUM_OF_FU-1:0][DATA_WIDTH-1:0]   cdb_val,
  output logic [NUM_OF_RS-1:0]                   rs_ready,
  input  logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0] rs_fu_assign,
  input  logic [NUM_OF_RS-1:0]                   rs_dispatch_en,
  output logic [NUM_OF_FU-1:0]                   fu_issue_valid,
  output logic [NUM_OF_FU-1:0][OP_WIDTH-1:0]     fu_issue_op,
  output logic [NUM_OF_FU-1:0][DATA_WIDTH-1:0]   fu_issue_src1,
  output logic [NUM_OF_FU-1:0][DATA_WIDTH-1:0]   fu_issue_src2,
  output logic [NUM_OF_FU-1:0][TAG_WIDTH-1:0]    fu_issue_dst_tag
);

  localparam int RS_IDX_WIDTH = (NUM_OF_RS <= 1) ? 1 : $clog2(NUM_OF_RS);

  rs_entry_t [NUM_OF_RS-1:0]                 ent;
  rs_src_t   [NUM_OF_RS-1:0]                 src1_nxt;
  rs_src_t   [NUM_OF_RS-1:0]                 src2_nxt;
  logic      [NUM_OF_RS-1:0]                 valid_vec;
  logic      [NUM_OF_RS-1:0]                 alloc_sel;
  logic      [NUM_OF_RS-1:0]                 disp_ok;
  logic      [NUM_OF_RS-1:0]                 issued;
  logic      [NUM_OF_RS-1:0]                 multi1;
  logic      [NUM_OF_RS-1:0]                 multi2;
  logic      [RS_IDX_WIDTH-1:0]              alloc_idx;
  logic                                      alloc_fire;
  logic      [NUM_OF_FU-1:0]                 fu_take;
  logic      [NUM_OF_FU-1:0][RS_IDX_WIDTH-1:0] fu_sel;
  rs_src_t                                   alloc_s1;
  rs_src_t                                   alloc_s2;

  assign alloc_s1    = {alloc_src1_rdy, alloc_src1_tag, alloc_src1_val};
  assign alloc_s2    = {alloc_src2_rdy, alloc_src2_tag, alloc_src2_val};
  assign alloc_ready = |(~valid_vec);
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  // Lowest free entry takes the allocation; readiness is purely registered state.
  always_comb begin
    alloc_idx = '0;
    alloc_sel = '0;
    for (int i = 0; i < NUM_OF_RS; i++) begin
      valid_vec[i] = ent[i].valid;
      rs_ready[i]  = ent[i].valid && ent[i].src1.rdy && ent[i].src2.rdy;
    end
    for (int i = NUM_OF_RS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = RS_IDX_WIDTH'(i);
    end
    for (int i = 0; i < NUM_OF_RS; i++) begin
      alloc_sel[i] = alloc_fire && (alloc_idx == RS_IDX_WIDTH'(i));
    end
  end

  // Each FU accepts the lowest-index ready entry granted to it; losers stay put.
  always_comb begin
    fu_take = '0;
    fu_sel  = '0;
    issued  = '0;
    disp_ok = rs_dispatch_en & rs_ready;
    for (int i = 0; i < NUM_OF_RS; i++) begin
      if (disp_ok[i] && (int'(rs_fu_assign[i]) < NUM_OF_FU)) begin
        if (!fu_take[rs_fu_assign[i]]) begin
          fu_take[rs_fu_assign[i]] = 1'b1;
          fu_sel[rs_fu_assign[i]]  = RS_IDX_WIDTH'(i);
          issued[i]                = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OF_RS; g++) begin : g_src
    rs_src_wakeup #(.NUM_OF_FU(NUM_OF_FU)) u_src1 (
      .active(ent[g].valid), .cur(ent[g].src1), .alloc_en(alloc_sel[g]),
      .alloc_src(alloc_s1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_val(cdb_val), .nxt(src1_nxt[g]), .multi_hit(multi1[g])
    );
    rs_src_wakeup #(.NUM_OF_FU(NUM_OF_FU)) u_src2 (
      .active(ent[g].valid), .cur(ent[g].src2), .alloc_en(alloc_sel[g]),
      .alloc_src(alloc_s2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_val(cdb_val), .nxt(src2_nxt[g]), .multi_hit(multi2[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent              <= '0;
      fu_issue_valid   <= '0;
      fu_issue_op      <= '0;
      fu_issue_src1    <= '0;
      fu_issue_src2    <= '0;
      fu_issue_dst_tag <= '0;
    end else begin
      for (int i = 0; i < NUM_OF_RS; i++) begin
        if (flush)             ent[i].valid <= 1'b0;
        else if (alloc_sel[i]) ent[i].valid <= 1'b1;
        else if (issued[i])    ent[i].valid <= 1'b0;
        if (alloc_sel[i]) begin
          ent[i].op      <= alloc_op;
          ent[i].dst_tag <= alloc_dst_tag;
        end
        ent[i].src1 <= src1_nxt[i];
        ent[i].src2 <= src2_nxt[i];
      end
      // Issue is registered from current state, so it survives a same-cycle flush.
      for (int k = 0; k < NUM_OF_FU; k++) begin
        fu_issue_valid[k]   <= fu_take[k];
        fu_issue_op[k]      <= fu_take[k] ? ent[fu_sel[k]].op       : '0;
        fu_issue_src1[k]    <= fu_take[k] ? ent[fu_sel[k]].src1.val : '0;
        fu_issue_src2[k]    <= fu_take[k] ? ent[fu_sel[k]].src2.val : '0;
        fu_issue_dst_tag[k] <= fu_take[k] ? ent[fu_sel[k]].dst_tag  : '0;
      end
    end
  end

  if (CHECK_PROTOCOL) begin : g_chk
    a_alloc_full: assert property (@(posedge clk) disable iff (!reset)
      !(alloc_valid && !alloc_ready));
    a_disp_not_ready: assert property (@(posedge clk) disable iff (!reset)
      (rs_dispatch_en & ~rs_ready) == '0);
    a_fu_conflict: assert property (@(posedge clk) disable iff (!reset)
      (disp_ok & ~issued) == '0);
    a_multi_lane: assert property (@(posedge clk) disable iff (!reset)
      !(|(multi1 | multi2)));
  end

endmodule

// File: doc/rs_alu_station.md
Name: rs_alu_station

Overview:
ALU reservation-station entry array. Sits directly upstream of RS_FU_SCHEDULER. Holds renamed ALU micro-ops until both source operands are available, snooping the CDB for wakeup. Drives rs_ready to the scheduler, consumes rs_dispatch_en/rs_fu_assign, and issues operand bundles to the ALUs through a registered per-FU issue port.

Parameters:
NUM_OF_RS, `RS_ALU_ENTRIES_NUM (8), number of entries.
NUM_OF_FU, `NUM_OF_ALUS (2), number of ALUs; also the number of CDB lanes.
FU_IDX_WIDTH, (NUM_OF_FU<=1)?1:$clog2(NUM_OF_FU), width of the FU index.
TAG_WIDTH, 6, physical-register tag width.
DATA_WIDTH, 32, operand width.
OP_WIDTH, 5, ALU opcode width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
flush  in  1  invalidate all entries.
alloc_valid  in  1  new micro-op offered.
alloc_ready  out  1  at least one free entry.
alloc_op  in  OP_WIDTH  opcode.
alloc_dst_tag  in  TAG_WIDTH  destination tag.
alloc_srcN_tag  in  TAG_WIDTH  source tag (N=1,2).
alloc_srcN_rdy  in  1  source value already valid.
alloc_srcN_val  in  DATA_WIDTH  source value when rdy.
cdb_valid  in  NUM_OF_FU  per-lane broadcast valid.
cdb_tag  in  TAG_WIDTH x NUM_OF_FU  broadcast tags.
cdb_val  in  DATA_WIDTH x NUM_OF_FU  broadcast values.
rs_ready  out  NUM_OF_RS  entry valid and both sources ready.
rs_fu_assign  in  FU_IDX_WIDTH x NUM_OF_RS  FU chosen per entry.
rs_dispatch_en  in  NUM_OF_RS  dispatch grant per entry.
fu_issue_valid  out  NUM_OF_FU  issue to ALU k.
fu_issue_op  out  OP_WIDTH x NUM_OF_FU  opcode.
fu_issue_src1/src2  out  DATA_WIDTH x NUM_OF_FU  operands.
fu_issue_dst_tag  out  TAG_WIDTH x NUM_OF_FU  destination tag.

Behaviour:
- Reset (reset==0 at posedge): all entries invalid; all fu_issue_* = 0; alloc_ready reads 1 after reset; rs_ready = 0.
- Entry state: valid, op, dst_tag, and per source {rdy, tag, val}. rs_ready[i] = valid & src1.rdy & src2.rdy, combinational from registered state.
- Allocation: when alloc_valid & alloc_ready, write the lowest-index invalid entry at the posedge. alloc_ready = |~valid (current state; an entry freed by dispatch this cycle is not reusable until the next cycle). alloc_valid while !alloc_ready is dropped and flagged by an assertion.
- Alloc bypass: if an incoming source is not rdy and its tag matches a valid CDB lane in the same cycle, write it rdy with that lane's value.
- Wakeup: each valid, not-ready source comparing equal to any valid cdb lane captures the value and sets rdy at the posedge. On a multi-lane match, the lowest lane wins (an assertion flags it). Earliest dispatch after wakeup is the next cycle (one-cycle wakeup-to-ready).
- Dispatch: on rs_dispatch_en[i], entry i is muxed to FU rs_fu_assign[i] and registered into fu_issue_*[k]. fu_issue_valid[k] is high exactly one cycle later, otherwise 0 (issue latency 1). Entry i is invalidated at the same edge.
- rs_dispatch_en[i] with !rs_ready[i] is ignored (assertion). Two grants to the same FU: the lowest entry index wins, the other entry is retained (assertion).
- Same cycle alloc + dispatch + wakeup are independent; a wakeup on an entry being dispatched has no effect.
- Flush: all entries invalid at the next edge. Flush takes priority over alloc. Issues registered in the flush cycle still appear (fu_issue_valid is not suppressed).
- Reset mid-operation discards all entries and any pending issue.

Decomposition:
- Shared package rs_pkg: rs_src_t {rdy, tag, val} and rs_entry_t {valid, op, dst_tag, src1, src2}. TAG_WIDTH/DATA_WIDTH/OP_WIDTH come from existing defines.
- One sub-module rs_src_wakeup: a single source's CDB compare, capture and alloc-bypass logic, instantiated 2 x NUM_OF_RS.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> alloc_ready=1, rs_ready=0, fu_issue_valid=0.
- Alloc with srcs ready (op=ADD, src1=5, src2=7, dst=3) -> entry 0 valid, rs_ready=8'b0000_0001 next cycle. Grant en[0], assign=1 -> fu_issue_valid=2'b10 with src1=5, src2=7, dst=3 one cycle later; rs_ready[0]=0.
- Alloc entry with src2 tag 9 not ready -> rs_ready[0]=0. cdb_valid[0]=1, tag=9, val=0xAB -> rs_ready[0]=1 next cycle; issued src2=0xAB.
- Alloc bypass: alloc src1 tag 4 not ready while cdb lane1 broadcasts tag 4 val 0x11 -> entry written rdy, rs_ready=1 next cycle.
- Fill 8 entries -> alloc_ready=0. Dispatch entry 3 -> alloc_ready=1 the cycle after, and the next alloc lands in entry 3.
- Grant entries 1 and 2 both to FU 0 -> only entry 1 issues; entry 2 stays valid and rs_ready[2]=1. Flush -> rs_ready=0, alloc_ready=1 next cycle.
